// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int CNT_W     = 4;
    localparam int LANE_W    = 8;
    localparam int NUM_LANES = 4;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 synchronous storage with per-byte write enables and a registered read port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk_i,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic [NUM_LANES-1:0]     be_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // NOTE: storage and its read register carry no reset; only control state needs a known value.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (be_i[i]) begin
                        mem_q[addr_i][i*LANE_W +: LANE_W] <= wdata_i[i*LANE_W +: LANE_W];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage load/store responder: accepts one word access, stalls the pipeline for
// LATENCY cycles, then strobes done_o with load data or an error flag.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        err_o,
    output logic        stall_o
);

    localparam int AW = $clog2(DEPTH);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   we_q, err_q;
    logic [NUM_LANES-1:0]   be_q;
    logic [AW-1:0]          widx_q;
    logic [31:0]            wdata_q;

    logic                   bad_addr;
    logic                   accept;
    logic                   mem_en;
    logic                   use_inputs;
    logic [31:0]            arr_rdata;

    assign bad_addr = (addr_i[1:0] != 2'b00) || (addr_i[31:2] >= 30'(DEPTH));
    assign accept   = (state_q == IDLE) && req_i;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_en     = 1'b0;
        use_inputs = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (bad_addr) begin
                        state_d = RESP;
                    end else if (LATENCY == 1) begin
                        // Single-cycle latency reaches the array straight from the port.
                        state_d    = RESP;
                        mem_en     = 1'b1;
                        use_inputs = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(LATENCY - 2);
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    mem_en  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            be_q    <= '0;
            widx_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= we_i;
                err_q   <= bad_addr;
                be_q    <= be_i;
                widx_q  <= addr_i[AW+1:2];
                wdata_q <= wdata_i;
            end
        end
    end

    dmem_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clk_i   (clk_i),
        .en_i    (mem_en),
        .we_i    (use_inputs ? we_i             : we_q),
        .be_i    (use_inputs ? be_i             : be_q),
        .addr_i  (use_inputs ? addr_i[AW+1:2]   : widx_q),
        .wdata_i (use_inputs ? wdata_i          : wdata_q),
        .rdata_o (arr_rdata)
    );

    // Reset masks the combinational IDLE stall so the freeze drops with rst_i.
    assign stall_o = (state_q == BUSY) || ((state_q == IDLE) && req_i && !rst_i);
    assign done_o  = (state_q == RESP);
    assign err_o   = done_o && err_q;
    assign rdata_o = (done_o && !err_q && !we_q) ? arr_rdata : 32'h0;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder on the CPU's MEM-stage load/store port. Accepts one word access per request, holds the pipeline via `stall_o` for a fixed latency, then returns read data or commits write data with byte enables. Replaces the single-cycle data memory so the hazard/stall path can be exercised against realistic memory latency.

## Interface
- `DEPTH`, 256: memory size in 32-bit words; power of two.
- `LATENCY`, 3: cycles from request acceptance to `done_o`; legal range 1..15.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `req_i`  in  1  access request from the MEM stage; sampled only in IDLE.
- `we_i`  in  1  1 = store, 0 = load.
- `be_i`  in  4  byte enables for stores; `be_i[0]` is bits 7:0. Ignored for loads.
- `addr_i`  in  32  byte address.
- `wdata_i`  in  32  store data.
- `rdata_o`  out  32  load data; valid only while `done_o`=1, else 0.
- `done_o`  out  1  one-cycle response strobe.
- `err_o`  out  1  qualifies `done_o`: access was misaligned or out of range.
- `stall_o`  out  1  freeze request to the pipeline.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: `stall_o` = `req_i` (combinational). On an edge with `req_i`=1, capture `we_i`, `be_i`, `addr_i`, `wdata_i` into request registers.
  - Bad access (`addr_i[1:0]`≠0 or `addr_i[31:2]` ≥ DEPTH): go to RESP with the error flag set. The memory is not accessed.
  - LATENCY=1: go to RESP.
  - Otherwise: go to BUSY and load the counter with LATENCY-2.
- BUSY: `stall_o`=1.
  - Counter 0: go to RESP. Counter >0: decrement.
  - On the edge leaving BUSY, a store commits to the array and a load latches the array word into `rdata_o`.
  - For LATENCY=1, the commit or latch happens on the IDLE→RESP edge.
- RESP, exactly one cycle:
  - `done_o`=1, `stall_o`=0, `err_o` = error flag.
  - `rdata_o` carries the latched word for a good load and 0 for stores and errors.
  - Next state is IDLE. `req_i` is ignored in this cycle; the pipeline advances and presents its next request in the following cycle.
- Input changes after acceptance are ignored.
- Store masking: only lanes with a set `be_i` bit are updated. `be_i`=0000 is a legal no-op store that still completes normally.
- Array address is `addr_i[log2(DEPTH)+1:2]`.

## Timing
- Reset values:
  - state = IDLE, counter = 0.
  - `done_o`, `err_o`, `stall_o` = 0; `rdata_o` = 0.
  - Request registers = 0.
  - Array contents are not reset.
- Good access accepted at edge N: `done_o` is high in the cycle after edge N+LATENCY-1, i.e. LATENCY cycles after the request cycle.
- Error access: `done_o`/`err_o` are high in the cycle immediately after acceptance, independent of LATENCY.
- Issue rate: at most one request per LATENCY+1 cycles, because the RESP cycle cannot accept a request.
- A load issued after a store to the same word returns the stored data; the store committed before its own RESP.
- Reset asserted in BUSY: return to IDLE immediately. A pending store is discarded and no `done_o` is produced. Reset in RESP drops `done_o` immediately.

## Structure
- Package `dmem_pkg`:
  - state enum {IDLE, BUSY, RESP}.
  - Counter width constant (4 bits).
  - Byte-lane width constant.
- Sub-module `dmem_array`:
  - Synchronous DEPTH×32 storage.
  - Write port with 4-bit byte enables.
  - Registered read port.
  - No reset.
- `dmem_responder` holds the FSM, counter, request registers, and error decode.

## Test plan
- Reset, then store 0xDEADBEEF at 0x10 with be=1111, LATENCY=3: `stall_o` high for 3 cycles, `done_o` in the 3rd cycle after the request, `err_o`=0. A following load from 0x10 returns 0xDEADBEEF.
- Store 0x000000AA at 0x10 with be=0001 over 0xDEADBEEF: a load returns 0xDEADBEAA. A store with be=0000 leaves 0xDEADBEAA unchanged.
- Load from 0x12 (misaligned) and from 0x400 with DEPTH=256: `done_o`=`err_o`=1 one cycle after the request, `rdata_o`=0, and word 0x10 is unchanged.
- LATENCY=1: back-to-back store then load to 0x20 (request, RESP, request, RESP) gives `done_o` on alternate cycles and returns the stored data.
- Assert reset during BUSY of a store of 0x12345678 to 0x30 after 0x30 was written 0x11111111: no `done_o`, a subsequent load returns 0x11111111, and `stall_o` drops asynchronously with reset.
- Change `addr_i`/`wdata_i` during BUSY: the response reflects the values captured at acceptance. `req_i` held high through RESP is not accepted until the next IDLE cycle.
